// File: rtl/mem_stage_p.sv
// MEM stage of the five-stage MIPS pipeline: word-organised data memory with sub-word access,
// W->E store-data forwarding, alignment flags, optional multi-cycle latency and the E->M register.
module mem_stage_p #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 3072,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned MEM_LAT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              MemReadE,
    input  logic [1:0]        SDtoRegE,
    input  logic [2:0]        MemOpE,
    input  logic [31:0]       ALUOutE,
    input  logic [DATA_W-1:0] WriteDataE,
    input  logic [4:0]        RtE,
    input  logic [4:0]        WriteRegE,
    input  logic [31:0]       PCE,
    input  logic              RegWriteW,
    input  logic [4:0]        WriteRegW,
    input  logic [DATA_W-1:0] ResultW,
    output logic              stall,
    output logic [DATA_W-1:0] ReadDataM,
    output logic [31:0]       ALUOutM,
    output logic [31:0]       PCM,
    output logic              RegWriteM,
    output logic [4:0]        WriteRegM,
    output logic [1:0]        SDtoRegM,
    output logic              AdELM,
    output logic              AdESM
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0]  LAT   = 2'(MEM_LAT);

    typedef enum logic {Idle, Busy} stateT;

    stateT             stateQ, stateD;
    logic [1:0]        cntQ, cntD;
    logic [DATA_W-1:0] holdQ, holdD;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wordIdx;
    logic              inRange;
    logic [DATA_W-1:0] rdWord;
    logic              fwd;
    logic [DATA_W-1:0] storeFwd, storeData;
    logic              misaligned;
    logic [7:0]        byteSel;
    logic [15:0]       halfSel;
    logic [DATA_W-1:0] loadData, mergeWord;
    logic              commit, memWe;
    logic              unusedAddrBits;

    assign wordIdx        = ALUOutE[ADDR_W+1:2];
    assign unusedAddrBits = ^ALUOutE[31:ADDR_W+2];
    assign inRange        = {1'b0, wordIdx} < (ADDR_W + 1)'(DEPTH);
    assign rdWord         = inRange ? mem[wordIdx[IDX_W-1:0]] : '0;

    assign fwd      = MemWriteE && RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RtE);
    assign storeFwd = fwd ? ResultW : WriteDataE;
    // With latency the data was captured in the first access cycle; later W results are stale.
    assign storeData = (MEM_LAT == 0) ? storeFwd : holdQ;

    always_comb begin
        misaligned = 1'b0;
        case (MemOpE)
            3'b000:         misaligned = |ALUOutE[1:0];
            3'b001, 3'b010: misaligned = ALUOutE[0];
            default:        misaligned = 1'b0;
        endcase
    end

    assign byteSel = rdWord[{ALUOutE[1:0], 3'b000} +: 8];
    assign halfSel = ALUOutE[1] ? rdWord[31:16] : rdWord[15:0];

    always_comb begin
        loadData = rdWord;
        case (MemOpE)
            3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
            3'b010:  loadData = {16'h0000, halfSel};
            3'b011:  loadData = {{24{byteSel[7]}}, byteSel};
            3'b100:  loadData = {24'h000000, byteSel};
            default: loadData = rdWord;
        endcase
    end

    always_comb begin
        mergeWord = rdWord;
        case (MemOpE)
            3'b000: mergeWord = storeData;
            3'b001, 3'b010: begin
                if (ALUOutE[1]) mergeWord[31:16] = storeData[15:0];
                else            mergeWord[15:0]  = storeData[15:0];
            end
            3'b011, 3'b100: mergeWord[{ALUOutE[1:0], 3'b000} +: 8] = storeData[7:0];
            default: mergeWord = rdWord;
        endcase
    end

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        holdD  = holdQ;
        stall  = 1'b0;
        commit = 1'b0;
        case (stateQ)
            Idle: begin
                if ((MemReadE || MemWriteE) && (LAT != 2'd0)) begin
                    stall  = 1'b1;
                    holdD  = storeFwd;
                    stateD = Busy;
                    cntD   = 2'd1;
                end else begin
                    commit = 1'b1;
                end
            end
            Busy: begin
                if (cntQ < LAT) begin
                    stall = 1'b1;
                    cntD  = cntQ + 2'd1;
                end else begin
                    commit = 1'b1;
                    stateD = Idle;
                    cntD   = 2'd0;
                end
            end
            default: stateD = Idle;
        endcase
    end

    assign memWe = commit && MemWriteE && !misaligned && inRange;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ <= Idle;
            cntQ   <= 2'd0;
            holdQ  <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            holdQ  <= holdD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (memWe) begin
            mem[wordIdx[IDX_W-1:0]] <= mergeWord;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || stall) begin
            ReadDataM <= '0;
            ALUOutM   <= '0;
            PCM       <= '0;
            RegWriteM <= 1'b0;
            WriteRegM <= '0;
            SDtoRegM  <= '0;
            AdELM     <= 1'b0;
            AdESM     <= 1'b0;
        end else begin
            ReadDataM <= (MemReadE && !misaligned) ? loadData : '0;
            ALUOutM   <= ALUOutE;
            PCM       <= PCE;
            RegWriteM <= RegWriteE;
            WriteRegM <= WriteRegE;
            SDtoRegM  <= SDtoRegE;
            AdELM     <= MemReadE && misaligned;
            AdESM     <= MemWriteE && misaligned;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && memWe) $display("@%h: *%h <= %h", PCE, wordIdx, mergeWord);
    end
`endif

endmodule

// File: tb/tb_mem_stage_p.sv
// Directed bench for mem_stage_p: a zero-latency instance and a MEM_LAT=2 instance share stimulus.
module tb_mem_stage_p;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteE, MemWriteE, MemReadE;
    logic [1:0]  SDtoRegE;
    logic [2:0]  MemOpE;
    logic [31:0] ALUOutE, WriteDataE, PCE, ResultW;
    logic [4:0]  RtE, WriteRegE, WriteRegW;
    logic        RegWriteW;

    logic        stall0, RegWriteM0, AdELM0, AdESM0;
    logic [31:0] ReadDataM0, ALUOutM0, PCM0;
    logic [4:0]  WriteRegM0;
    logic [1:0]  SDtoRegM0;

    logic        stall2, RegWriteM2, AdELM2, AdESM2;
    logic [31:0] ReadDataM2, ALUOutM2, PCM2;
    logic [4:0]  WriteRegM2;
    logic [1:0]  SDtoRegM2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_stage_p #(.MEM_LAT(0)) dut0 (
        .clk(clk), .reset(reset), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .MemReadE(MemReadE), .SDtoRegE(SDtoRegE), .MemOpE(MemOpE), .ALUOutE(ALUOutE),
        .WriteDataE(WriteDataE), .RtE(RtE), .WriteRegE(WriteRegE), .PCE(PCE),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW), .stall(stall0),
        .ReadDataM(ReadDataM0), .ALUOutM(ALUOutM0), .PCM(PCM0), .RegWriteM(RegWriteM0),
        .WriteRegM(WriteRegM0), .SDtoRegM(SDtoRegM0), .AdELM(AdELM0), .AdESM(AdESM0)
    );

    mem_stage_p #(.DEPTH(64), .MEM_LAT(2)) dut2 (
        .clk(clk), .reset(reset), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .MemReadE(MemReadE), .SDtoRegE(SDtoRegE), .MemOpE(MemOpE), .ALUOutE(ALUOutE),
        .WriteDataE(WriteDataE), .RtE(RtE), .WriteRegE(WriteRegE), .PCE(PCE),
        .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW), .stall(stall2),
        .ReadDataM(ReadDataM2), .ALUOutM(ALUOutM2), .PCM(PCM2), .RegWriteM(RegWriteM2),
        .WriteRegM(WriteRegM2), .SDtoRegM(SDtoRegM2), .AdELM(AdELM2), .AdESM(AdESM2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic setIn(input logic rw, input logic mw, input logic mr, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] pc,
                         input logic [4:0] rt, input logic [4:0] wr);
        RegWriteE  = rw;
        MemWriteE  = mw;
        MemReadE   = mr;
        MemOpE     = op;
        ALUOutE    = addr;
        WriteDataE = wd;
        PCE        = pc;
        RtE        = rt;
        WriteRegE  = wr;
    endtask

    task automatic setW(input logic rw, input logic [4:0] wr, input logic [31:0] res);
        RegWriteW = rw;
        WriteRegW = wr;
        ResultW   = res;
    endtask

    task automatic nop();
        setIn(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
        SDtoRegE = 2'd0;
        setW(1'b0, 5'd0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        nop();
        tick();
        tick();
        check("rst_readdata", ReadDataM0, 32'h0);
        check("rst_regwrite", 32'(RegWriteM0), 32'h0);
        check("rst_pcm", PCM0, 32'h0);
        check("rst_stall0", 32'(stall0), 32'h0);
        check("rst_stall2", 32'(stall2), 32'h0);
        reset = 1'b0;

        // Zero-latency instance: one instruction per cycle.
        setIn(1'b1, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h100, 5'd0, 5'd2); tick();
        check("lw0_data", ReadDataM0, 32'h0);
        check("lw0_regwrite", 32'(RegWriteM0), 32'h1);
        check("lw0_writereg", 32'(WriteRegM0), 32'h2);
        check("lw0_pcm", PCM0, 32'h100);

        setIn(1'b0, 1'b1, 1'b0, 3'b000, 32'h10, 32'h12345678, 32'h104, 5'd3, 5'd0); tick();
        check("sw_aluout", ALUOutM0, 32'h10);
        check("sw_ades", 32'(AdESM0), 32'h0);

        setIn(1'b1, 1'b0, 1'b1, 3'b011, 32'h11, 32'h0, 32'h108, 5'd0, 5'd4); tick();
        check("lb_11", ReadDataM0, 32'h00000056);
        setIn(1'b1, 1'b0, 1'b1, 3'b100, 32'h13, 32'h0, 32'h10c, 5'd0, 5'd4); tick();
        check("lbu_13", ReadDataM0, 32'h00000012);
        setIn(1'b1, 1'b0, 1'b1, 3'b001, 32'h12, 32'h0, 32'h110, 5'd0, 5'd4); tick();
        check("lh_12", ReadDataM0, 32'h00001234);

        setIn(1'b0, 1'b1, 1'b0, 3'b011, 32'h21, 32'h000000FF, 32'h114, 5'd3, 5'd0); tick();
        setIn(1'b1, 1'b0, 1'b1, 3'b000, 32'h20, 32'h0, 32'h118, 5'd0, 5'd4); tick();
        check("sb_word", ReadDataM0, 32'h0000FF00);
        setIn(1'b1, 1'b0, 1'b1, 3'b011, 32'h21, 32'h0, 32'h11c, 5'd0, 5'd4); tick();
        check("lb_21", ReadDataM0, 32'hFFFFFFFF);
        setIn(1'b1, 1'b0, 1'b1, 3'b001, 32'h20, 32'h0, 32'h120, 5'd0, 5'd4); tick();
        check("lh_20", ReadDataM0, 32'hFFFFFF00);

        // Store-data forwarding from W.
        setIn(1'b0, 1'b1, 1'b0, 3'b000, 32'h30, 32'h0, 32'h124, 5'd5, 5'd0);
        setW(1'b1, 5'd5, 32'hCAFEBABE); tick();
        setW(1'b0, 5'd0, 32'h0);
        setIn(1'b1, 1'b0, 1'b1, 3'b000, 32'h30, 32'h0, 32'h128, 5'd0, 5'd4); tick();
        check("fwd_hit", ReadDataM0, 32'hCAFEBABE);

        setIn(1'b0, 1'b1, 1'b0, 3'b000, 32'h30, 32'h0, 32'h12c, 5'd0, 5'd0);
        setW(1'b1, 5'd0, 32'hCAFEBABE); tick();
        setW(1'b0, 5'd0, 32'h0);
        setIn(1'b1, 1'b0, 1'b1, 3'b000, 32'h30, 32'h0, 32'h130, 5'd0, 5'd4); tick();
        check("fwd_r0", ReadDataM0, 32'h0);

        setIn(1'b0, 1'b1, 1'b0, 3'b000, 32'h38, 32'h11111111, 32'h134, 5'd5, 5'd0);
        setW(1'b1, 5'd6, 32'hCAFEBABE); tick();
        setW(1'b0, 5'd0, 32'h0);
        setIn(1'b1, 1'b0, 1'b1, 3'b000, 32'h38, 32'h0, 32'h138, 5'd0, 5'd4); tick();
        check("fwd_miss", ReadDataM0, 32'h11111111);

        // Alignment faults.
        setIn(1'b0, 1'b1, 1'b0, 3'b001, 32'h3, 32'h0000BEEF, 32'h13c, 5'd3, 5'd0); tick();
        check("sh_ades", 32'(AdESM0), 32'h1);
        check("sh_adel", 32'(AdELM0), 32'h0);
        setIn(1'b1, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h140, 5'd0, 5'd4); tick();
        check("sh_nowrite", ReadDataM0, 32'h0);
        setIn(1'b1, 1'b0, 1'b1, 3'b000, 32'h12, 32'h0, 32'h144, 5'd0, 5'd4); tick();
        check("lw_adel", 32'(AdELM0), 32'h1);
        check("lw_adel_data", ReadDataM0, 32'h0);

        // Index range and ignored upper address bits.
        setIn(1'b0, 1'b1, 1'b0, 3'b000, 32'h3000, 32'h99999999, 32'h148, 5'd3, 5'd0); tick();
        setIn(1'b1, 1'b0, 1'b1, 3'b000, 32'h3000, 32'h0, 32'h14c, 5'd0, 5'd4); tick();
        check("oor_read", ReadDataM0, 32'h0);
        setIn(1'b1, 1'b0, 1'b1, 3'b000, 32'h4010, 32'h0, 32'h150, 5'd0, 5'd4); tick();
        check("alias_read", ReadDataM0, 32'h12345678);

        setIn(1'b1, 1'b0, 1'b0, 3'b000, 32'hDEAD, 32'h0, 32'h154, 5'd0, 5'd7);
        SDtoRegE = 2'd2; tick();
        check("alu_aluout", ALUOutM0, 32'hDEAD);
        check("alu_sdtoreg", 32'(SDtoRegM0), 32'h2);
        check("alu_writereg", 32'(WriteRegM0), 32'h7);

        // Reset clears memory.
        reset = 1'b1; nop(); tick();
        reset = 1'b0;
        setIn(1'b1, 1'b0, 1'b1, 3'b000, 32'h10, 32'h0, 32'h158, 5'd0, 5'd4); tick();
        check("rst_memclear", ReadDataM0, 32'h0);
        reset = 1'b1; nop(); tick(); tick();
        reset = 1'b0;

        // MEM_LAT=2 instance: sw with forwarded data, ResultW changes during BUSY.
        setIn(1'b0, 1'b1, 1'b0, 3'b000, 32'h8, 32'hA5A5A5A5, 32'h200, 5'd4, 5'd0);
        setW(1'b1, 5'd4, 32'h5A5A1234);
        #1;
        check("lat_sw_stall_c0", 32'(stall2), 32'h1);
        tick();
        check("lat_sw_stall_c1", 32'(stall2), 32'h1);
        check("lat_sw_bubble_c1", PCM2, 32'h0);
        setW(1'b1, 5'd4, 32'hFFFFFFFF);
        tick();
        check("lat_sw_stall_c2", 32'(stall2), 32'h0);
        check("lat_sw_bubble_c2", PCM2, 32'h0);
        tick();
        check("lat_sw_pcm", PCM2, 32'h200);
        check("lat_sw_aluout", ALUOutM2, 32'h8);

        setIn(1'b1, 1'b0, 1'b1, 3'b000, 32'h8, 32'h0, 32'h204, 5'd0, 5'd9);
        setW(1'b0, 5'd0, 32'h0);
        #1;
        check("lat_lw_stall_c0", 32'(stall2), 32'h1);
        tick();
        check("lat_lw_stall_c1", 32'(stall2), 32'h1);
        check("lat_lw_bubble_c1", 32'(WriteRegM2), 32'h0);
        tick();
        check("lat_lw_stall_c2", 32'(stall2), 32'h0);
        tick();
        check("lat_lw_data", ReadDataM2, 32'h5A5A1234);
        check("lat_lw_writereg", 32'(WriteRegM2), 32'h9);
        nop();
        #1;
        check("lat_idle_stall", 32'(stall2), 32'h0);

        // Reset while BUSY abandons the store.
        setIn(1'b0, 1'b1, 1'b0, 3'b000, 32'hC, 32'h77777777, 32'h208, 5'd0, 5'd0);
        tick();
        reset = 1'b1;
        nop();
        tick();
        check("busy_rst_stall", 32'(stall2), 32'h0);
        check("busy_rst_pcm", PCM2, 32'h0);
        reset = 1'b0;
        setIn(1'b1, 1'b0, 1'b1, 3'b000, 32'hC, 32'h0, 32'h20c, 5'd0, 5'd4);
        tick(); tick(); tick();
        check("busy_rst_nowrite", ReadDataM2, 32'h0);
        nop();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage_p.md
# mem_stage_p

Parametrised MEM stage for the five-stage MIPS pipeline: data memory plus the E→M pipeline register. Adds byte/halfword loads and stores with sign/zero extension, clean W→E store-data forwarding, alignment-exception flags, and a configurable multi-cycle memory latency with a stall handshake. It sits between the execute stage and the writeback stage.

## Interface
- DATA_W, 32, datapath width; only 32 is supported.
- DEPTH, 3072, memory size in words; power of two not required.
- ADDR_W, 12, word-index width, ≥ clog2(DEPTH).
- MEM_LAT, 0, extra wait cycles per memory access, 0..3.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- RegWriteE, MemWriteE, MemReadE  in  1 each  control from E.
- SDtoRegE  in  2  writeback select; passed through.
- MemOpE  in  3  access size: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned. Stores use 000/001/011.
- ALUOutE  in  32  byte address for memory ops, otherwise the ALU result.
- WriteDataE  in  32  store data as read in E.
- RtE  in  5  source register of the store data.
- WriteRegE  in  5  destination register.
- PCE  in  32  PC of the instruction in E.
- RegWriteW  in  1  W-stage write enable, for forwarding.
- WriteRegW  in  5  W-stage destination, for forwarding.
- ResultW  in  32  W-stage result, for forwarding.
- stall  out  1  upstream must hold all E inputs while high.
- ReadDataM, ALUOutM, PCM  out  32  pipeline-register outputs.
- RegWriteM  out  1  pipeline-register output.
- WriteRegM  out  5  pipeline-register output.
- SDtoRegM  out  2  pipeline-register output.
- AdELM, AdESM  out  1  misaligned load / misaligned store flag, registered.

## Operation
- Memory: DEPTH×32 array.
  - Index is ALUOutE[ADDR_W+1:2]; higher address bits are ignored.
  - An index ≥ DEPTH reads 0 and suppresses the write.
  - Lanes are little-endian: byte k lives in bits 8k+7:8k.
- Store data forwarding:
  - Forward when MemWriteE && RegWriteW && WriteRegW≠0 && WriteRegW==RtE; the store data is then ResultW, otherwise WriteDataE.
- Store lane placement:
  - sw writes the full word.
  - sh writes the low half of the store data into lanes {1,0} or {3,2}, selected by ALUOutE[1].
  - sb writes the low byte into lane ALUOutE[1:0].
  - Untouched lanes keep their old value.
- Load lane selection:
  - The lane is selected by the same address bits.
  - Signed ops sign-extend to 32 bits; unsigned ops zero-extend.
  - Reads are combinational from the array; the result is registered into ReadDataM.
- Alignment:
  - Word ops need ALUOutE[1:0]==0; half ops need ALUOutE[0]==0.
  - A violation sets AdELM (load) or AdESM (store) with the instruction.
  - A misaligned store performs no write; a misaligned load returns ReadDataM=0.
- Latency FSM (states IDLE, BUSY; counter cnt of 2 bits):
  - MEM_LAT=0: the FSM never leaves IDLE and stall stays 0.
  - IDLE, with an access (MemReadE|MemWriteE) and MEM_LAT>0:
    - stall=1, combinational in that same cycle.
    - Latch the forwarded store data into a holding register.
    - Next state BUSY, cnt←1.
  - BUSY, cnt<MEM_LAT: stall=1, cnt←cnt+1.
  - BUSY, cnt==MEM_LAT: stall=0; commit the access, using the latched store data; load the pipeline register; return to IDLE.
  - A new access presented in the commit cycle's successor starts a fresh sequence from IDLE.
- Pipeline register:
  - When stall=1 it loads a bubble: every M output is 0.
  - Otherwise it loads the E values, the load data and the flags.
- Debug: each committed store prints `$display("@%h: *%h <= %h", PCE, word_addr, merged_word)`.

## Timing
- Reset state:
  - All M outputs are 0, stall=0, the FSM is in IDLE with cnt=0, and the holding register is 0.
  - All memory words are 0 one cycle after reset asserts.
- Reset mid-access: the FSM returns to IDLE next edge, with no write and no ReadDataM.
- Each store commits exactly once, on the commit edge.
- Access latency:
  - An access occupies MEM_LAT+1 cycles in E.
  - Results appear on the M outputs the edge after commit.
  - Non-memory instructions take 1 cycle.
- Forwarded data is sampled only in the first cycle of the access. Changes on ResultW while in BUSY are ignored.
- Read-after-write: a load in the cycle after a store to the same word sees the new data.

## Test plan
- Reset with MEM_LAT=0 -> all M outputs 0; lw from 0x0 gives ReadDataM=0.
- sw 0x12345678 @0x10, then lb @0x11, then lbu @0x13, then lh @0x12 -> ReadDataM = 0x00000056, 0x00000012, 0x00001234.
- sb 0xFF @0x21 over a word holding 0 -> word = 0x0000FF00; lb @0x21 = 0xFFFFFFFF.
- Store with WriteRegW=RtE=5, RegWriteW=1, ResultW=0xCAFEBABE, WriteDataE=0 -> memory holds 0xCAFEBABE. Repeat with WriteRegW=0 -> memory holds 0.
- MEM_LAT=2, sw then lw -> stall high for 2 cycles per access with bubbles on M; each store prints once; lw returns the stored value.
- sh @0x3 -> AdESM=1 and no memory change. lw @0x2 -> AdELM=1, ReadDataM=0. Reset asserted in BUSY -> no write, stall=0 next cycle.
